// File: rtl/ballot_collector.sv
// Session controller in front of the 4-voter majority decoder. It collects one
// ballot per voter, freezes the yes-vector, and latches the decoder's verdict.
//
// state  | meaning
// IDLE   | no session since reset; votes cleared, no ballots taken
// OPEN   | poll open; ballots accepted, timeout timer running
// SETTLE | votes frozen for one cycle while the decoder output settles
// DONE   | verdict latched and held until the next open_poll
module ballot_collector #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       open_poll,
  input  logic       close_poll,
  input  logic       ballot_valid,
  output logic       ballot_ready,
  input  logic [1:0] ballot_id,
  input  logic       ballot_yes,
  output logic [3:0] votes,
  input  logic [2:0] verdict_in,
  output logic [2:0] result,
  output logic       result_valid,
  output logic [3:0] cast_mask,
  output logic       reject,
  output logic       error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OPEN   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] timer;

  logic [3:0] id_onehot;
  logic [3:0] mask_nxt;
  logic       accept;
  logic       dup;
  logic       exit_open;
  logic       verdict_ok;

  assign ballot_ready = (state == S_OPEN);

  always_comb begin
    id_onehot = 4'b0001 << ballot_id;
    accept    = ballot_valid & ballot_ready;
    dup       = accept & (|(cast_mask & id_onehot));
    mask_nxt  = accept ? (cast_mask | id_onehot) : cast_mask;
    // The fourth ballot closes the poll in the same cycle it is accepted.
    exit_open = close_poll | (mask_nxt == 4'b1111) | (timer == TIMER_LAST);
    case (verdict_in)
      3'b100, 3'b010, 3'b001: verdict_ok = 1'b1;
      default:                verdict_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      votes        <= '0;
      cast_mask    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      reject       <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (open_poll) begin
            state        <= S_OPEN;
            timer        <= '0;
            votes        <= '0;
            cast_mask    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
          end
        end
        S_OPEN: begin
          if (timer != TIMER_LAST) timer <= timer + CNT_W'(1);
          if (accept && !dup) begin
            cast_mask        <= mask_nxt;
            votes[ballot_id] <= ballot_yes;
          end
          reject <= dup;
          if (exit_open) state <= S_SETTLE;
        end
        S_SETTLE: begin
          result       <= verdict_ok ? verdict_in : 3'b000;
          error        <= ~verdict_ok;
          result_valid <= 1'b1;
          state        <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector; a small majority-decoder model drives
// verdict_in from votes, with an override for corrupt-verdict cases.
module tb_ballot_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       open_poll, close_poll, ballot_valid, ballot_yes;
  logic [1:0] ballot_id;
  logic       ballot_ready;
  logic [3:0] votes, cast_mask;
  logic [2:0] verdict_in, result;
  logic       result_valid, reject, error;

  logic       force_en;
  logic [2:0] force_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] decode(input logic [3:0] v);
    int n;
    n = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    if (n <= 1) return 3'b100;
    else if (n == 2) return 3'b010;
    else return 3'b001;
  endfunction

  assign verdict_in = force_en ? force_val : decode(votes);

  ballot_collector #(.TIMEOUT_CYCLES(8), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
    .ballot_valid(ballot_valid), .ballot_ready(ballot_ready),
    .ballot_id(ballot_id), .ballot_yes(ballot_yes), .votes(votes),
    .verdict_in(verdict_in), .result(result), .result_valid(result_valid),
    .cast_mask(cast_mask), .reject(reject), .error(error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_session();
    open_poll = 1'b1;
    tick();
    open_poll = 1'b0;
  endtask

  task automatic cast(input logic [1:0] id, input logic yes);
    ballot_valid = 1'b1;
    ballot_id    = id;
    ballot_yes   = yes;
    tick();
    ballot_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({votes, cast_mask, result, result_valid, error, reject, ballot_ready} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got votes=%b mask=%b result=%b rv=%b err=%b rej=%b rdy=%b, want all 0",
               votes, cast_mask, result, result_valid, error, reject, ballot_ready);
    end
  endtask

  task automatic test_full_cast();
    open_session();
    checks++;
    if (ballot_ready !== 1'b1) begin
      errors++; $display("FAIL open_ready: got %b want 1", ballot_ready);
    end
    ballot_valid = 1'b1;
    ballot_id = 2'd0; ballot_yes = 1'b1; tick();
    ballot_id = 2'd1; ballot_yes = 1'b1; tick();
    ballot_id = 2'd2; ballot_yes = 1'b1; tick();
    ballot_id = 2'd3; ballot_yes = 1'b0; tick();
    ballot_valid = 1'b0;
    checks++;
    if (cast_mask !== 4'b1111 || votes !== 4'b0111) begin
      errors++; $display("FAIL full_cast_votes: got mask=%b votes=%b want 1111/0111", cast_mask, votes);
    end
    checks++;
    if (ballot_ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL full_cast_settle: got rdy=%b rv=%b want 0/0", ballot_ready, result_valid);
    end
    tick();
    checks++;
    if (result !== 3'b001 || result_valid !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL full_cast_result: got result=%b rv=%b err=%b want 001/1/0", result, result_valid, error);
    end
  endtask

  task automatic test_close_early();
    open_session();
    checks++;
    if (cast_mask !== 4'b0000 || result_valid !== 1'b0 || result !== 3'b000) begin
      errors++; $display("FAIL reopen_clear: got mask=%b rv=%b result=%b want 0000/0/000", cast_mask, result_valid, result);
    end
    cast(2'd1, 1'b1);
    cast(2'd2, 1'b1);
    open_poll = 1'b1;
    tick();
    open_poll = 1'b0;
    checks++;
    if (ballot_ready !== 1'b1) begin
      errors++; $display("FAIL open_in_open: got rdy=%b want 1", ballot_ready);
    end
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    tick();
    checks++;
    if (votes !== 4'b0110 || result !== 3'b010 || result_valid !== 1'b1 || cast_mask !== 4'b0110) begin
      errors++; $display("FAIL close_early: got votes=%b result=%b rv=%b mask=%b want 0110/010/1/0110",
                         votes, result, result_valid, cast_mask);
    end
    ballot_valid = 1'b1; ballot_id = 2'd0; ballot_yes = 1'b1;
    tick();
    ballot_valid = 1'b0;
    checks++;
    if (reject !== 1'b0 || cast_mask !== 4'b0110 || votes !== 4'b0110) begin
      errors++; $display("FAIL done_ignores_ballot: got rej=%b mask=%b votes=%b want 0/0110/0110", reject, cast_mask, votes);
    end
  endtask

  task automatic test_duplicate();
    open_session();
    cast(2'd2, 1'b1);
    cast(2'd2, 1'b0);
    checks++;
    if (reject !== 1'b1 || votes !== 4'b0100 || cast_mask !== 4'b0100) begin
      errors++; $display("FAIL dup_reject: got rej=%b votes=%b mask=%b want 1/0100/0100", reject, votes, cast_mask);
    end
    tick();
    checks++;
    if (reject !== 1'b0) begin
      errors++; $display("FAIL dup_pulse_width: got rej=%b want 0", reject);
    end
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    tick();
    checks++;
    if (result !== 3'b100 || result_valid !== 1'b1) begin
      errors++; $display("FAIL dup_result: got result=%b rv=%b want 100/1", result, result_valid);
    end
  endtask

  task automatic test_dup_with_close();
    open_session();
    cast(2'd0, 1'b1);
    ballot_valid = 1'b1; ballot_id = 2'd0; ballot_yes = 1'b0; close_poll = 1'b1;
    tick();
    ballot_valid = 1'b0; close_poll = 1'b0;
    checks++;
    if (reject !== 1'b1 || ballot_ready !== 1'b0 || votes !== 4'b0001) begin
      errors++; $display("FAIL dup_close: got rej=%b rdy=%b votes=%b want 1/0/0001", reject, ballot_ready, votes);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    open_session();
    n = 0;
    while (ballot_ready === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL timeout_cycles: got %0d cycles in OPEN want 8", n);
    end
    tick();
    checks++;
    if (votes !== 4'b0000 || result !== 3'b100 || result_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_result: got votes=%b result=%b rv=%b want 0000/100/1", votes, result, result_valid);
    end
  endtask

  task automatic test_bad_verdict();
    open_session();
    cast(2'd3, 1'b1);
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    force_en = 1'b1; force_val = 3'b011;
    tick();
    force_en = 1'b0;
    checks++;
    if (error !== 1'b1 || result !== 3'b000 || result_valid !== 1'b1) begin
      errors++; $display("FAIL bad_verdict: got err=%b result=%b rv=%b want 1/000/1", error, result, result_valid);
    end
    open_session();
    checks++;
    if (error !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL reopen_clears_error: got err=%b rv=%b want 0/0", error, result_valid);
    end
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    open_session();
    cast(2'd0, 1'b1);
    cast(2'd1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (votes !== 4'b0000 || cast_mask !== 4'b0000 || ballot_ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got votes=%b mask=%b rdy=%b rv=%b want 0000/0000/0/0",
                         votes, cast_mask, ballot_ready, result_valid);
    end
    open_session();
    cast(2'd3, 1'b1);
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    tick();
    checks++;
    if (result !== 3'b100 || cast_mask !== 4'b1000 || votes !== 4'b1000) begin
      errors++; $display("FAIL post_reset_session: got result=%b mask=%b votes=%b want 100/1000/1000", result, cast_mask, votes);
    end
    open_session();
    checks++;
    if (cast_mask !== 4'b0000 || votes !== 4'b0000 || ballot_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL restart_from_done: got mask=%b votes=%b rdy=%b rv=%b want 0000/0000/1/0",
                         cast_mask, votes, ballot_ready, result_valid);
    end
  endtask

  initial begin
    rst = 1'b1; open_poll = 1'b0; close_poll = 1'b0; ballot_valid = 1'b0;
    ballot_id = 2'd0; ballot_yes = 1'b0; force_en = 1'b0; force_val = 3'b000;
    #1;
    test_reset();
    test_full_cast();
    test_close_early();
    test_duplicate();
    test_dup_with_close();
    test_timeout();
    test_bad_verdict();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Upstream session controller for the combinational 4-voter majority decoder.
- Opens a poll and accepts one ballot per voter over a valid/ready handshake.
- Closes the poll on command, when all four voters have cast, or on timeout.
- Presents the stable 4-bit yes-vector to the decoder, samples its 3-bit one-hot verdict back, and holds it as the session result.

Parameters:
- TIMEOUT_CYCLES, 1000: cycles in OPEN before the poll auto-closes. Must be at least 2.
- CNT_W, 10: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- open_poll  input  1  start a new session; honoured in IDLE and DONE only.
- close_poll  input  1  end the session early; honoured in OPEN only.
- ballot_valid  input  1  ballot offered.
- ballot_ready  output  1  collector can accept a ballot.
- ballot_id  input  2  voter index 0..3; maps to votes bit index.
- ballot_yes  input  1  1 = yes, 0 = no.
- votes  output  4  recorded yes-vector to the decoder; bit n = voter n.
- verdict_in  input  3  decoder verdict, one-hot:
  - 100 = reject (≤1 yes)
  - 010 = tie (2 yes)
  - 001 = pass (≥3 yes)
- result  output  3  latched verdict.
- result_valid  output  1  result holds a valid session verdict.
- cast_mask  output  4  bit n set once voter n has cast.
- reject  output  1  one-cycle pulse: duplicate ballot refused.
- error  output  1  sampled verdict was not one-hot.

Behaviour:
- Reset (synchronous, any state, including mid-session):
  - state=IDLE.
  - votes, cast_mask, result = 0.
  - result_valid, error, reject, ballot_ready = 0.
  - Timer = 0.
- States: IDLE, OPEN, SETTLE, DONE.
- IDLE:
  - ballot_ready=0; votes=0.
  - open_poll → OPEN; clears votes, cast_mask, result, result_valid, error and the timer.
- OPEN:
  - ballot_ready=1. Timer increments every cycle.
  - A ballot is accepted when ballot_valid & ballot_ready.
  - Accepted ballot with cast_mask[ballot_id]=0: next cycle cast_mask[ballot_id]=1 and votes[ballot_id]=ballot_yes.
  - Accepted ballot with cast_mask[ballot_id]=1: not recorded; reject=1 on the next cycle for exactly one cycle.
  - Exit to SETTLE on the first of:
    - close_poll;
    - cast_mask becomes 4'b1111;
    - timer == TIMEOUT_CYCLES-1.
  - A ballot accepted on the same cycle as any exit condition is recorded.
  - open_poll while in OPEN is ignored.
  - Voters who never cast count as no (bit 0).
- SETTLE:
  - Exactly one cycle; ballot_ready=0; votes held stable.
  - At the end of the cycle, verdict_in is captured into result. Next state DONE.
  - result_valid=1 from the first DONE cycle.
  - If the captured value is not one of {100, 010, 001}: error=1 and result=000.
- DONE:
  - result, result_valid, error, votes and cast_mask held.
  - ballot_ready=0; ballots offered here are ignored and produce no reject.
  - open_poll → OPEN with the same clears as from IDLE.
- Latency:
  - Ballot handshake to cast_mask update: 1 cycle.
  - Exit condition to result_valid: 2 cycles (OPEN→SETTLE→DONE).
- Simultaneous events:
  - rst overrides all other inputs.
  - close_poll and timeout on the same cycle: single transition to SETTLE.
  - Duplicate ballot on the same cycle as close_poll: reject pulse still issued; poll still closes.
- Timer:
  - CNT_W bits; runs only in OPEN; does not wrap within a session.
  - Cleared on entry to OPEN.

Test Plan:
- Reset, then open_poll. Ballots: id0 yes, id1 yes, id2 yes, id3 no, back-to-back.
  → cast_mask=1111; auto-close; votes=0111; decoder returns 001; result=001, result_valid=1 two cycles after the 4th ballot.
- Open; id1 yes, id2 yes; close_poll.
  → votes=0110; result=010; unvoted bits 0 and 3 stay 0.
- Open; id2 yes, then id2 no.
  → second ballot gives reject=1 for one cycle; votes[2] stays 1; cast_mask=0100.
- Open; no ballots; TIMEOUT_CYCLES=8.
  → SETTLE entered 8 cycles after OPEN; votes=0000; result=100.
- Force verdict_in=011 during SETTLE.
  → error=1, result=000, result_valid=1.
- Mid-session rst after two ballots.
  → next cycle IDLE, votes=0, cast_mask=0, ballot_ready=0. Then open_poll from DONE restarts cleanly with cast_mask=0000.
